// File: rtl/cv32e40p_irq_pkg.sv
// Shared types and constants for the interrupt source: line ids, standard
// machine-level line numbers and the default mask of raisable lines.
package cv32e40p_irq_pkg;

  typedef logic [4:0] irq_id_t;

  localparam irq_id_t IRQ_MSI = 5'd3;
  localparam irq_id_t IRQ_MTI = 5'd7;
  localparam irq_id_t IRQ_MEI = 5'd11;

  // Fast lines 31..16 plus MEI/MTI/MSI; everything else is reserved.
  localparam logic [31:0] IRQ_LEGAL_MASK = 32'hFFFF_0888;

  function automatic logic [31:0] irq_onehot(input irq_id_t id);
    return 32'd1 << id;
  endfunction

endpackage

// File: rtl/cv32e40p_irq_source_if.sv
// Requester-side interrupt bundle: raise/clear requests, core ack and the
// status flags.
interface cv32e40p_irq_source_if import cv32e40p_irq_pkg::*; #(
  parameter int CNT_W = 16
);

  logic             req_valid_i;
  irq_id_t          req_id_i;
  logic             req_ready_o;
  logic             clr_valid_i;
  irq_id_t          clr_id_i;
  logic [31:0]      irq_o;
  logic             irq_ack_i;
  irq_id_t          irq_id_i;
  logic             illegal_req_o;
  logic             spurious_ack_o;
  logic             busy_o;
  logic [CNT_W-1:0] ack_count_o;

  modport master (
    output req_valid_i, req_id_i, clr_valid_i, clr_id_i, irq_ack_i, irq_id_i,
    input  req_ready_o, irq_o, illegal_req_o, spurious_ack_o, busy_o, ack_count_o
  );

  modport slave (
    input  req_valid_i, req_id_i, clr_valid_i, clr_id_i, irq_ack_i, irq_id_i,
    output req_ready_o, irq_o, illegal_req_o, spurious_ack_o, busy_o, ack_count_o
  );

endinterface

// File: rtl/cv32e40p_irq_timeout_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module cv32e40p_irq_timeout_cnt #(
  parameter int W   = 11,
  parameter int MAX = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)
      cnt_o <= '0;
    else if (inc_i && (cnt_o != W'(MAX)))
      cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/cv32e40p_irq_source.sv
// Interrupt requester: 32-bit pending register driving the core's irq lines.
// Define CV32E40P_IRQ_TIMEOUT_EN to add the sticky no-ack timeout_o output.
module cv32e40p_irq_source import cv32e40p_irq_pkg::*; #(
  parameter logic [31:0] LEGAL_MASK  = IRQ_LEGAL_MASK,
  parameter int          CNT_W       = 16
`ifdef CV32E40P_IRQ_TIMEOUT_EN
  , parameter int        TIMEOUT_CYC = 1024
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cv32e40p_irq_source_if.slave  bus
`ifdef CV32E40P_IRQ_TIMEOUT_EN
  , output logic                timeout_o
`endif
);

  logic [31:0]      pend_q, pend_d;
  logic [31:0]      set_mask, ack_mask, clr_mask;
  logic             req_acc, req_legal, ack_hit;
  logic             illegal_q, spurious_q;
  logic [CNT_W-1:0] ack_cnt_q;

  always_comb begin
    req_acc   = bus.req_valid_i & ~pend_q[bus.req_id_i];
    req_legal = LEGAL_MASK[bus.req_id_i];
    ack_hit   = bus.irq_ack_i & pend_q[bus.irq_id_i];
    set_mask  = (req_acc && req_legal) ? irq_onehot(bus.req_id_i) : 32'd0;
    ack_mask  = ack_hit                ? irq_onehot(bus.irq_id_i) : 32'd0;
    clr_mask  = bus.clr_valid_i        ? irq_onehot(bus.clr_id_i) : 32'd0;
    // set_mask never overlaps a pending bit because ready gates acceptance
    pend_d    = ((pend_q & ~ack_mask & ~clr_mask) | set_mask) & LEGAL_MASK;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      illegal_q  <= 1'b0;
      spurious_q <= 1'b0;
      ack_cnt_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      illegal_q  <= req_acc & ~req_legal;
      spurious_q <= bus.irq_ack_i & ~pend_q[bus.irq_id_i];
      if (ack_hit && !(&ack_cnt_q))
        ack_cnt_q <= ack_cnt_q + 1'b1;
    end
  end

  assign bus.req_ready_o    = ~pend_q[bus.req_id_i];
  assign bus.irq_o          = pend_q;
  assign bus.busy_o         = |pend_q;
  assign bus.illegal_req_o  = illegal_q;
  assign bus.spurious_ack_o = spurious_q;
  assign bus.ack_count_o    = ack_cnt_q;

`ifdef CV32E40P_IRQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_at_max, tmo_q;

  // Restart the window on any valid ack or once nothing is left pending.
  cv32e40p_irq_timeout_cnt #(
    .W   (TW),
    .MAX (TIMEOUT_CYC)
  ) u_tmo_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bus.busy_o & ~ack_hit),
    .clr_i (ack_hit | ~(|pend_d)),
    .cnt_o (tmo_cnt)
  );

  assign tmo_at_max = (tmo_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk_i) begin
    if (rst_i)
      tmo_q <= 1'b0;
    else if (tmo_at_max)
      tmo_q <= 1'b1;
  end

  assign timeout_o = tmo_q | tmo_at_max;
`endif

endmodule

// File: tb/tb_cv32e40p_irq_source.sv
// Directed bench: the driver pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cv32e40p_irq_source;
  import cv32e40p_irq_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tmo;
  always #5 clk = ~clk;

  cv32e40p_irq_source_if #(.CNT_W(CNT_W)) bus ();

`ifdef CV32E40P_IRQ_TIMEOUT_EN
  cv32e40p_irq_source #(.CNT_W(CNT_W), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave), .timeout_o(tmo));
`else
  cv32e40p_irq_source #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave));
  assign tmo = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]      irq;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             ill;
    logic             spur;
    logic             rdy;
    logic             tmo;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_t;

  sb_t sbq[$];
  int  total = 0;
  int  bad   = 0;

  function automatic obs_t o(input logic [31:0] irq, input int cnt, input bit ill,
                             input bit spur, input bit rdy, input bit t = 1'b0);
    obs_t r;
    r.irq  = irq;
    r.busy = |irq;
    r.cnt  = CNT_W'(cnt);
    r.ill  = ill;
    r.spur = spur;
    r.rdy  = rdy;
    r.tmo  = t;
    return r;
  endfunction

  // Inputs applied just after a posedge; exp describes outputs seen during that cycle.
  task automatic step(input string nm, input bit r, input bit rv, input int rid,
                      input bit av, input int aid, input bit cv, input int cid,
                      input obs_t exp);
    sb_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.req_valid_i = rv;
    bus.req_id_i    = irq_id_t'(rid);
    bus.irq_ack_i   = av;
    bus.irq_id_i    = irq_id_t'(aid);
    bus.clr_valid_i = cv;
    bus.clr_id_i    = irq_id_t'(cid);
    e.name = nm;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      sb_t  e;
      obs_t a;
      e = sbq.pop_front();
      a = {bus.irq_o, bus.busy_o, bus.ack_count_o, bus.illegal_req_o,
           bus.spurious_ack_o, bus.req_ready_o, tmo};
      total++;
      if (a !== e.exp) begin
        bad++;
        $display("FAIL %s: got irq=%h busy=%b cnt=%0d ill=%b spur=%b rdy=%b tmo=%b, want irq=%h busy=%b cnt=%0d ill=%b spur=%b rdy=%b tmo=%b",
                 e.name, a.irq, a.busy, a.cnt, a.ill, a.spur, a.rdy, a.tmo,
                 e.exp.irq, e.exp.busy, e.exp.cnt, e.exp.ill, e.exp.spur, e.exp.rdy, e.exp.tmo);
      end
    end
  end

  initial begin
    bus.req_valid_i = 1'b1;
    bus.req_id_i    = IRQ_MEI;
    bus.irq_ack_i   = 1'b0;
    bus.irq_id_i    = '0;
    bus.clr_valid_i = 1'b0;
    bus.clr_id_i    = '0;

    //    name            rst rv rid av aid cv cid  expected outputs this cycle
    step("rst0",          1, 1, 11, 0, 0,  0, 0,  o(32'h0, 0, 0, 0, 1));
    step("rst1",          1, 1, 11, 0, 0,  0, 0,  o(32'h0, 0, 0, 0, 1));
    step("post_rst",      0, 0, 0,  0, 0,  0, 0,  o(32'h0, 0, 0, 0, 1));
    step("req11",         0, 1, 11, 0, 0,  0, 0,  o(32'h0, 0, 0, 0, 1));
    step("irq11_up",      0, 0, 0,  0, 0,  0, 0,  o(32'h800, 0, 0, 0, 1));
    step("ack11",         0, 0, 0,  1, 11, 0, 0,  o(32'h800, 0, 0, 0, 1));
    step("irq11_down",    0, 0, 0,  0, 0,  0, 0,  o(32'h0, 1, 0, 0, 1));
    step("req5",          0, 1, 5,  0, 0,  0, 0,  o(32'h0, 1, 0, 0, 1));
    step("illegal_pulse", 0, 0, 0,  0, 0,  0, 0,  o(32'h0, 1, 1, 0, 1));
    step("ack3_spur",     0, 0, 0,  1, 3,  0, 0,  o(32'h0, 1, 0, 0, 1));
    step("spur_pulse",    0, 0, 0,  0, 0,  0, 0,  o(32'h0, 1, 0, 1, 1));
    step("spur_once",     0, 0, 0,  0, 0,  0, 0,  o(32'h0, 1, 0, 0, 1));
    step("req16",         0, 1, 16, 0, 0,  0, 0,  o(32'h0, 1, 0, 0, 1));
    step("bp_ack16",      0, 1, 16, 1, 16, 0, 0,  o(32'h10000, 1, 0, 0, 0));
    step("bp_retry",      0, 1, 16, 0, 0,  0, 0,  o(32'h0, 2, 0, 0, 1));
    step("irq16_again",   0, 0, 0,  0, 0,  0, 0,  o(32'h10000, 2, 0, 0, 1));
    step("req3_clr16",    0, 1, 3,  0, 0,  1, 16, o(32'h10000, 2, 0, 0, 1));
    step("req31",         0, 1, 31, 0, 0,  0, 0,  o(32'h8, 2, 0, 0, 1));
    step("conc",          0, 1, 7,  1, 3,  1, 31, o(32'h80000008, 2, 0, 0, 1));
    step("conc_res",      0, 0, 0,  0, 0,  0, 0,  o(32'h80, 3, 0, 0, 1));
    step("ack_clr7",      0, 0, 0,  1, 7,  1, 7,  o(32'h80, 3, 0, 0, 1));
    step("ack_clr7_res",  0, 0, 0,  0, 0,  0, 0,  o(32'h0, 4, 0, 0, 1));
    step("clr_idle20",    0, 0, 0,  0, 0,  1, 20, o(32'h0, 4, 0, 0, 1));
    step("clr_silent",    0, 0, 0,  0, 0,  0, 0,  o(32'h0, 4, 0, 0, 1));
    step("req11b",        0, 1, 11, 0, 0,  0, 0,  o(32'h0, 4, 0, 0, 1));
    step("rst_mid",       1, 1, 7,  1, 11, 0, 0,  o(32'h800, 4, 0, 0, 1));
    step("rst_mid_res",   0, 0, 0,  0, 0,  0, 0,  o(32'h0, 0, 0, 0, 1));
`ifdef CV32E40P_IRQ_TIMEOUT_EN
    step("t_req3",        0, 1, 3,  0, 0,  0, 0,  o(32'h0, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 9; k++)
      step($sformatf("t_wait%0d", k), 0, 0, 0, 0, 0, 0, 0, o(32'h8, 0, 0, 0, 1, k == 9));
    step("t_ack3",        0, 0, 0,  1, 3,  0, 0,  o(32'h8, 0, 0, 0, 1, 1));
    step("t_sticky",      0, 0, 0,  0, 0,  0, 0,  o(32'h0, 1, 0, 0, 1, 1));
`endif

    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending checks, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_irq_source.md
Name: cv32e40p_irq_source

Overview:
- Drives the core's level-sensitive irq lines and consumes the core's acknowledge (irq_ack/irq_id); it is the requester end of the interrupt interface.
- Holds a 32-bit pending register. Bits are set by a request handshake from a sequence or driver and cleared by a core acknowledge or an explicit clear.
- Used as the DUT-side interrupt stimulus generator and reference model in the interrupt agent.

Parameters:
- LEGAL_MASK, 32'hFFFF_0888, lines that may be raised (irq[31:16], MEI 11, MTI 7, MSI 3); all other lines are permanently 0.
- CNT_W, 16, width of the saturating acknowledge counter.
- TIMEOUT_CYC, 1024, cycles without an ack while any line is pending before a timeout is flagged (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  raise-request valid.
- req_id_i  in  5  line index to raise.
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
- clr_valid_i  in  1  software clear of one line (no ack expected).
- clr_id_i  in  5  line index to clear.
- irq_o  out  32  interrupt lines to the core (irq_i of the core).
- irq_ack_i  in  1  core acknowledge, one-cycle pulse.
- irq_id_i  in  5  acknowledged index; valid only when irq_ack_i=1.
- illegal_req_o  out  1  one-cycle pulse: an accepted request targeted a reserved line.
- spurious_ack_o  out  1  one-cycle pulse: ack of a non-pending line.
- busy_o  out  1  any line pending.
- ack_count_o  out  CNT_W  valid acks since reset, saturating.

Behaviour:
- Reset (synchronous, active-high): pending register P=0, so irq_o=0. illegal_req_o=0, spurious_ack_o=0, busy_o=0, ack_count_o=0. Reset asserted mid-operation drops all lines the next edge; any in-flight ack or request that cycle is discarded.
- irq_o = P (registered). busy_o = |P (combinational from P).
- req_ready_o = ~P[req_id_i] (combinational). A pending line cannot be re-raised until it is cleared.
- Request handshake: accepted when req_valid_i & req_ready_o.
  - Legal line (LEGAL_MASK[id]=1): set P[id] at the next edge.
  - Reserved line: P unchanged, illegal_req_o pulses the next cycle.
- Ack handling when irq_ack_i=1:
  - P[irq_id_i]=1: clear the bit at the next edge; ack_count_o increments, saturating at all-ones.
  - P[irq_id_i]=0: spurious_ack_o pulses the next cycle; no state change; counter unchanged.
- Clear when clr_valid_i=1: clear P[clr_id_i] at the next edge. No counter change, no error flag, and clearing a non-pending line is silent.
- Next-state equation: P_next = (P & ~ack_mask & ~clr_mask) | set_mask. Because of req_ready, set_mask can never hit a currently pending bit.
- Simultaneous events in one cycle:
  - Ack of line A plus request of line A: ready=0, so the request stalls and the line drops. The request is accepted the following cycle if still held.
  - Ack and clear of the same line: the line clears once, the ack counts, no spurious flag.
  - Ack, clear and request on different lines: all take effect in the same edge.
- Latency: request accept to irq_o high is 1 cycle. Ack to irq_o low is 1 cycle.
- irq_id_i is ignored when irq_ack_i=0.

Optional Feature:
- Macro CV32E40P_IRQ_TIMEOUT_EN.
- Defined:
  - Adds output timeout_o (1 bit, sticky, cleared only by reset).
  - The internal counter increments each cycle while busy_o=1 and no valid ack occurs.
  - The counter resets to 0 on a valid ack or when P becomes 0.
  - timeout_o sets when the counter reaches TIMEOUT_CYC, and the counter holds at that value.
- Undefined: no timeout_o port and no counter logic.

Decomposition:
- Package cv32e40p_irq_pkg contains:
  - typedef irq_id_t (logic [4:0]);
  - constants IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11;
  - IRQ_LEGAL_MASK=32'hFFFF_0888, used as the LEGAL_MASK default.
- Sub-module cv32e40p_irq_timeout_cnt: parameterised saturating counter with an inc/clr interface, instantiated only under CV32E40P_IRQ_TIMEOUT_EN.

Test Plan:
- Reset: assert rst_i for 2 cycles with req_valid_i=1, id 11 → irq_o=0, busy_o=0, ack_count_o=0 throughout reset.
- Raise and ack: request id 11 → irq_o=32'h0000_0800 after 1 cycle. Ack id 11 → irq_o=0 after 1 cycle, ack_count_o=1.
- Illegal and spurious: request id 5 → irq_o stays 0, illegal_req_o pulses once. Ack id 3 with nothing pending → spurious_ack_o pulses once, ack_count_o unchanged.
- Back-pressure: with id 16 pending, request id 16 → req_ready_o=0. Same cycle ack id 16 → line drops, request accepted next cycle, irq_o[16]=1 again 2 cycles after the ack.
- Concurrency: in one cycle request id 7, ack id 3 (pending) and clear id 31 (pending) → next cycle irq_o=32'h0000_0080, ack_count_o +1.
- Timeout (macro on, TIMEOUT_CYC=8): raise id 3, withhold ack → timeout_o=1 at cycle 8 after busy_o rises and stays set after a later ack.
